// File: rtl/aes_sbox_responder.sv
// AES S-box lookup responder: four-phase address/data handshake, registered
// substituted byte, completed-lookup counter.
// Optional inverse table: define AES_SBOX_INV_EN to compile it in.
module aes_sbox_responder #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_address_sent,
  input  logic [7:0]       sbox_rqst_addr,
  input  logic             inv_sel,
  output logic             addr_ack,
  output logic [7:0]       sbox_read_data,
  output logic             flag_data_sent,
  input  logic             data_ack,
  output logic             busy,
  output logic [CNT_W-1:0] lookup_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, RELEASE} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef AES_SBOX_INV_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  logic inv_q;
`else
  logic unused_inv_sel;
  assign unused_inv_sel = inv_sel;
`endif

  state_t           state, state_nxt;
  logic [3:0]       wait_cnt;
  logic [7:0]       addr_q;
  logic [10:0]      tbl_idx;
  logic [7:0]       table_out;
  logic             capture, fire, consume;

  // Bit offset of entry addr_q: (255 - addr_q) * 8.
  assign tbl_idx = {~addr_q, 3'b000};

  // Combinational table read from the frozen address/selector.
  always_comb begin
    table_out = SBOX_FWD[tbl_idx +: 8];
`ifdef AES_SBOX_INV_EN
    if (inv_q) table_out = SBOX_INV[tbl_idx +: 8];
`endif
  end

  // Next-state and per-state action strobes.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    fire      = 1'b0;
    consume   = 1'b0;
    unique case (state)
      IDLE: if (flag_address_sent) begin
        capture   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (wait_cnt == 4'd0) begin
        fire      = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (data_ack) begin
        consume   = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: if (!flag_address_sent && !data_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state != IDLE);

  // Capture, wait countdown, response and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q         <= '0;
`ifdef AES_SBOX_INV_EN
      inv_q          <= 1'b0;
`endif
      wait_cnt       <= '0;
      addr_ack       <= 1'b0;
      flag_data_sent <= 1'b0;
      sbox_read_data <= '0;
      lookup_count   <= '0;
    end else begin
      if (capture) begin
        addr_q   <= sbox_rqst_addr;
`ifdef AES_SBOX_INV_EN
        inv_q    <= inv_sel;
`endif
        addr_ack <= 1'b1;
        wait_cnt <= WAIT_LOAD;
      end
      if (state == WAIT && !fire) wait_cnt <= wait_cnt - 4'd1;
      if (fire) begin
        sbox_read_data <= table_out;
        flag_data_sent <= 1'b1;
      end
      if (consume) begin
        flag_data_sent <= 1'b0;
        addr_ack       <= 1'b0;
        lookup_count   <= lookup_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_sbox_responder.sv
// Self-checking bench for aes_sbox_responder: two instances (LATENCY=1/CNT_W=16
// and LATENCY=4/CNT_W=4), S-box expectations computed from GF(2^8) arithmetic.
module tb_aes_sbox_responder;

  localparam int unsigned L0 = 1;
  localparam int unsigned W0 = 16;
  localparam int unsigned L1 = 4;
  localparam int unsigned W1 = 4;

`ifdef AES_SBOX_INV_EN
  localparam bit INV_BUILD = 1'b1;
`else
  localparam bit INV_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fas  [2];
  logic          isel [2];
  logic          dack [2];
  logic [7:0]    addr [2];
  logic          ack  [2];
  logic          fds  [2];
  logic          bsy  [2];
  logic [7:0]    rd   [2];
  logic [W0-1:0] cnt0;
  logic [W1-1:0] cnt1;

  aes_sbox_responder #(.LATENCY(L0), .CNT_W(W0)) dut0 (
    .clk(clk), .rst(rst), .flag_address_sent(fas[0]), .sbox_rqst_addr(addr[0]),
    .inv_sel(isel[0]), .addr_ack(ack[0]), .sbox_read_data(rd[0]),
    .flag_data_sent(fds[0]), .data_ack(dack[0]), .busy(bsy[0]), .lookup_count(cnt0)
  );

  aes_sbox_responder #(.LATENCY(L1), .CNT_W(W1)) dut1 (
    .clk(clk), .rst(rst), .flag_address_sent(fas[1]), .sbox_rqst_addr(addr[1]),
    .inv_sel(isel[1]), .addr_ack(ack[1]), .sbox_read_data(rd[1]),
    .flag_data_sent(fds[1]), .data_ack(dack[1]), .busy(bsy[1]), .lookup_count(cnt1)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb[$];
  int unsigned exp_cnt [2];
  logic [7:0]  fwd_t [256];
  logic [7:0]  inv_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] cur_cnt(input int d);
    return (d == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_cnt(input int d);
    int unsigned w;
    w = (d == 0) ? W0 : W1;
    exp_cnt[d] = (exp_cnt[d] + 1) % (32'd1 << w);
  endtask

  // One full transaction on instance d with optional mid-WAIT disturbances.
  task automatic lookup(input int d, input logic [7:0] a, input logic sel,
                        input bit chg, input bit drop_req, input int ack_delay,
                        input bit hold_req);
    int unsigned lat;
    int          n;
    logic [7:0]  got;
    lat = (d == 0) ? L0 : L1;
    addr[d] = a; isel[d] = sel; fas[d] = 1'b1; dack[d] = 1'b0;
    step();
    chk("req_ack", 32'(ack[d]), 32'd1);
    chk("req_busy", 32'(bsy[d]), 32'd1);
    chk("req_fds_low", 32'(fds[d]), 32'd0);
    sb.push_back((sel && INV_BUILD) ? inv_t[a] : fwd_t[a]);
    if (chg) begin
      addr[d] = ~a; isel[d] = ~sel;
    end
    if (drop_req) fas[d] = 1'b0;
    n = 0;
    while (fds[d] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    got = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    chk("data", 32'(rd[d]), 32'(got));
    for (int i = 0; i < ack_delay; i++) begin
      step();
      chk("hold_data", 32'(rd[d]), 32'(got));
      chk("hold_fds", 32'(fds[d]), 32'd1);
    end
    dack[d] = 1'b1;
    step();
    bump_cnt(d);
    chk("ack_fds_low", 32'(fds[d]), 32'd0);
    chk("ack_addr_ack_low", 32'(ack[d]), 32'd0);
    chk("count", cur_cnt(d), exp_cnt[d]);
    if (hold_req) begin
      fas[d] = 1'b1; dack[d] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step();
        chk("release_busy", 32'(bsy[d]), 32'd1);
        chk("release_no_capture", 32'(ack[d]), 32'd0);
      end
    end
    fas[d] = 1'b0; dack[d] = 1'b0;
    step();
    chk("idle_busy", 32'(bsy[d]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) fwd_t[i] = sbox_model(8'(i));
    for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
    for (int d = 0; d < 2; d++) begin
      fas[d] = 1'b0; isel[d] = 1'b0; dack[d] = 1'b0; addr[d] = 8'h00; exp_cnt[d] = 0;
    end
    rst = 1'b1;
    step(); step();
    chk("rst_ack", 32'(ack[0]), 32'd0);
    chk("rst_fds", 32'(fds[0]), 32'd0);
    chk("rst_data", 32'(rd[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_count", cur_cnt(0), 32'd0);
    rst = 1'b0;
    step();

    // Asynchronous reset in the middle of WAIT on the LATENCY=4 instance.
    addr[1] = 8'h53; fas[1] = 1'b1;
    step();
    fas[1] = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ack", 32'(ack[1]), 32'd0);
    chk("async_rst_fds", 32'(fds[1]), 32'd0);
    chk("async_rst_data", 32'(rd[1]), 32'd0);
    chk("async_rst_busy", 32'(bsy[1]), 32'd0);
    chk("async_rst_count", cur_cnt(1), 32'd0);
    sb.delete();
    #1 rst = 1'b0;
    step();
    lookup(1, 8'h00, 1'b0, 0, 0, 0, 0);

    // Forward lookups at LATENCY=1.
    lookup(0, 8'h00, 1'b0, 0, 0, 0, 0);
    lookup(0, 8'h01, 1'b0, 0, 0, 0, 0);
    lookup(0, 8'h53, 1'b0, 0, 0, 0, 0);
    lookup(0, 8'hff, 1'b0, 0, 0, 0, 0);

    // LATENCY=4, address and selector changed during WAIT, then request withdrawn.
    lookup(1, 8'h53, 1'b0, 1, 0, 0, 0);
    lookup(1, 8'hc4, 1'b0, 1, 1, 1, 0);

    // Delayed ack with the request held high through RELEASE.
    lookup(0, 8'h9a, 1'b0, 0, 0, 10, 1);

    // Inverse selector: inverse table only when the option is compiled in.
    lookup(0, 8'h63, 1'b1, 0, 0, 0, 0);
    lookup(0, 8'h00, 1'b1, 0, 0, 0, 0);
    lookup(0, 8'hed, 1'b1, 1, 0, 2, 0);

    // Mixed random lookups.
    for (int i = 0; i < 6; i++)
      lookup(0, 8'($urandom_range(255)), 1'($urandom_range(1)), 0, 0, i % 3, 0);

    // Counter wrap on the 4-bit instance: reach 17 completed lookups.
    while (exp_cnt[1] != 1 || checks < 40) begin
      lookup(1, 8'($urandom_range(255)), 1'b0, 0, 0, 0, 0);
      if (exp_cnt[1] == 1) break;
    end
    chk("wrap_count", cur_cnt(1), 32'd1);

    // data_ack pulsed in IDLE is ignored.
    dack[1] = 1'b1;
    step();
    dack[1] = 1'b0;
    step();
    chk("idle_ack_count", cur_cnt(1), 32'd1);
    chk("idle_ack_busy", 32'(bsy[1]), 32'd0);
    chk("idle_ack_fds", 32'(fds[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
